// File: rtl/tie_bank_ctrl.sv
// tie_bank_ctrl: bank of NUM_CH flop-driven constant ties. Each tie can be
// rewritten one at a time until the bank is frozen by lock.
// Optional build macro: TIE_BANK_READBACK_EN adds the rd_idx/rd_val readback port.
module tie_bank_ctrl #(
  parameter int unsigned          NUM_CH    = 8,
  parameter logic [NUM_CH-1:0]    RESET_VAL = NUM_CH'(8'h0F),
  parameter int unsigned          IDX_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_val,
  input  logic              lock,
  output logic [NUM_CH-1:0] tie_out,
  output logic              locked,
  output logic              err
`ifdef TIE_BANK_READBACK_EN
  ,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_val
`endif
);

  localparam int unsigned   CMP_W  = IDX_W + 1;
  localparam logic [IDX_W:0] CH_LIM = CMP_W'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    apply_idx;
  logic                apply_val;
  logic                lock_pend;
  logic                lock_pend_nxt;
  logic                capture_c;
  logic                reject_c;
  logic                accept_c;
  logic                in_range_c;
  logic [NUM_CH-1:0]   tie_nxt;

  // Handshake decode: a write is consumed whenever ready is high.
  always_comb begin
    accept_c   = wr_valid && wr_ready;
    in_range_c = ({1'b0, wr_idx} < CH_LIM);
  end

  // Next-state logic; a lock seen alongside a write is held until APPLY ends.
  always_comb begin
    state_nxt     = state;
    lock_pend_nxt = lock_pend;
    capture_c     = 1'b0;
    reject_c      = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c && in_range_c) begin
          state_nxt     = APPLY;
          capture_c     = 1'b1;
          lock_pend_nxt = lock;
        end else begin
          reject_c = accept_c;
          if (lock) begin
            state_nxt = LOCKED;
          end
        end
      end
      APPLY: begin
        state_nxt     = (lock || lock_pend) ? LOCKED : IDLE;
        lock_pend_nxt = 1'b0;
      end
      LOCKED: begin
        reject_c = accept_c;
      end
      default: begin
        state_nxt     = IDLE;
        lock_pend_nxt = 1'b0;
      end
    endcase
  end

  // Next tie vector: only the captured channel changes, on the edge leaving APPLY.
  always_comb begin
    tie_nxt = tie_out;
    if (state == APPLY) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (apply_idx == IDX_W'(i)) begin
          tie_nxt[i] = apply_val;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_pend <= lock_pend_nxt;
    end
  end

  // Write capture; contents are don't-care outside APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      apply_idx <= '0;
      apply_val <= 1'b0;
    end else if (capture_c) begin
      apply_idx <= wr_idx;
      apply_val <= wr_val;
    end
  end

  // Registered outputs, all derived from next state so they align with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tie_out  <= RESET_VAL;
      locked   <= 1'b0;
      err      <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      tie_out  <= tie_nxt;
      locked   <= (state_nxt == LOCKED);
      err      <= reject_c;
      wr_ready <= (state_nxt != APPLY);
    end
  end

`ifdef TIE_BANK_READBACK_EN
  logic rd_bit_c;

  // Readback mux; indices past the bank read as 0.
  always_comb begin
    rd_bit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_bit_c = tie_out[i];
      end
    end
  end

  // One-cycle registered readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_val <= 1'b0;
    end else begin
      rd_val <= rd_bit_c;
    end
  end
`endif

endmodule

// File: tb/tb_tie_bank_ctrl.sv
// Directed self-checking bench for tie_bank_ctrl (NUM_CH=8, IDX_W=4 so that
// out-of-range indices are expressible). Define TIE_BANK_READBACK_EN to also
// exercise the readback port.
module tb_tie_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_idx;
  logic       wr_val;
  logic       lock;
  logic [7:0] tie_out;
  logic       locked;
  logic       err;
`ifdef TIE_BANK_READBACK_EN
  logic [3:0] rd_idx;
  logic       rd_val;
`endif

  int errors = 0;
  int checks = 0;

  tie_bank_ctrl #(
    .NUM_CH   (8),
    .RESET_VAL(8'h0F),
    .IDX_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_idx  (wr_idx),
    .wr_val  (wr_val),
    .lock    (lock),
    .tie_out (tie_out),
    .locked  (locked),
    .err     (err)
`ifdef TIE_BANK_READBACK_EN
    ,
    .rd_idx  (rd_idx),
    .rd_val  (rd_val)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit before sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic val);
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_val   = val;
  endtask

  task automatic idle_in();
    wr_valid = 1'b0;
    wr_idx   = 4'd0;
    wr_val   = 1'b0;
    lock     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
`ifdef TIE_BANK_READBACK_EN
    rd_idx = 4'd0;
`endif
    // Reset held: outputs pinned to reset values
    wr(4'd3, 1'b0);
    lock = 1'b1;
    cyc(); cyc();
    chk("rst_tie",   tie_out, 8'h0F);
    chk("rst_lock",  8'(locked), 8'h00);
    chk("rst_err",   8'(err), 8'h00);
    chk("rst_ready", 8'(wr_ready), 8'h01);
    idle_in();
    rst = 1'b0;
    cyc();

    // Write idx7=1: ready low in APPLY, tie updates one cycle later
    wr(4'd7, 1'b1);
    cyc();
    idle_in();
    chk("w7_ready_apply", 8'(wr_ready), 8'h00);
    chk("w7_tie_apply",   tie_out, 8'h0F);
    cyc();
    chk("w7_tie",   tie_out, 8'h8F);
    chk("w7_ready", 8'(wr_ready), 8'h01);

`ifdef TIE_BANK_READBACK_EN
    rd_idx = 4'd7;
    cyc();
    chk("rd7", 8'(rd_val), 8'h01);
    rd_idx = 4'd4;
    cyc();
    chk("rd4", 8'(rd_val), 8'h00);
    rd_idx = 4'd9;
    cyc();
    chk("rd9_oor", 8'(rd_val), 8'h00);
`endif

    // Write idx5=1, with a second write offered during APPLY that must be dropped
    wr(4'd5, 1'b1);
    cyc();
    wr(4'd6, 1'b1);
    cyc();
    chk("w5_tie",       tie_out, 8'hAF);
    chk("w5_ready",     8'(wr_ready), 8'h01);
    chk("apply_no_err", 8'(err), 8'h00);
    idle_in();
    cyc();
    chk("apply_drop", tie_out, 8'hAF);

    // Out-of-range write: single err pulse, no change
    wr(4'd9, 1'b0);
    cyc();
    idle_in();
    chk("oor_err",   8'(err), 8'h01);
    chk("oor_ready", 8'(wr_ready), 8'h01);
    chk("oor_tie",   tie_out, 8'hAF);
    cyc();
    chk("oor_err_clr", 8'(err), 8'h00);

    // Back-to-back rejected writes give back-to-back pulses
    wr(4'd9, 1'b1);
    cyc();
    chk("b2b_err0", 8'(err), 8'h01);
    wr(4'd12, 1'b0);
    cyc();
    chk("b2b_err1", 8'(err), 8'h01);
    idle_in();
    cyc();
    chk("b2b_err_clr", 8'(err), 8'h00);
    chk("b2b_tie",     tie_out, 8'hAF);

    // Reset during APPLY discards the pending write
    wr(4'd0, 1'b0);
    cyc();
    idle_in();
    chk("rstap_ready", 8'(wr_ready), 8'h00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstap_tie",   tie_out, 8'h0F);
    chk("rstap_lock",  8'(locked), 8'h00);
    chk("rstap_ready", 8'(wr_ready), 8'h01);
    cyc();
    chk("rstap_tie_hold", tie_out, 8'h0F);

    // Write idx0=0 with lock in the same cycle: write lands, then LOCKED
    wr(4'd0, 1'b0);
    lock = 1'b1;
    cyc();
    idle_in();
    chk("lw_ready_apply", 8'(wr_ready), 8'h00);
    chk("lw_lock_apply",  8'(locked), 8'h00);
    cyc();
    chk("lw_tie",   tie_out, 8'h0E);
    chk("lw_lock",  8'(locked), 8'h01);
    chk("lw_ready", 8'(wr_ready), 8'h01);
    wr(4'd1, 1'b0);
    cyc();
    idle_in();
    chk("lk_err", 8'(err), 8'h01);
    chk("lk_tie", tie_out, 8'h0E);
    cyc();
    chk("lk_err_clr",  8'(err), 8'h00);
    chk("lk_sticky",   8'(locked), 8'h01);
    chk("lk_tie_hold", tie_out, 8'h0E);

    // Lock in IDLE, then any write is rejected
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    lock = 1'b1;
    cyc();
    lock = 1'b0;
    chk("li_lock", 8'(locked), 8'h01);
    wr(4'd3, 1'b0);
    cyc();
    idle_in();
    chk("li_err", 8'(err), 8'h01);
    chk("li_tie", tie_out, 8'h0F);

    // Lock asserted during APPLY: write completes, then LOCKED
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr(4'd4, 1'b1);
    cyc();
    idle_in();
    lock = 1'b1;
    cyc();
    lock = 1'b0;
    chk("la_tie",  tie_out, 8'h1F);
    chk("la_lock", 8'(locked), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
